updown_cmd_gen: RTL and testbench

Command generator that sits directly upstream of the 4-bit synchronous up/down counter and drives its step-enable (`t`) and direction (`M`) inputs. Two raw push-button inputs are synchronised, debounced and edge-detected, then arbitrated into single, well-formed step commands. Commands are refused at the count limits using the counter's `q` feedback. `M` is always set up one full cycle before `t` pulses, so the counter's combinational toggle terms never see a direction change during a step.

---
 rtl/updown_pkg.sv | 10 +
 rtl/updown_cmd_gen_btn_debounce.sv | 76 +++++++
 rtl/updown_cmd_gen.sv | 83 ++++++++
 tb/tb_updown_cmd_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter command generator.
package updown_pkg;
  typedef enum logic [1:0] {IDLE, ARM, STEP} state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] CNT_MIN = 4'h0;
endpackage

// File: rtl/updown_cmd_gen_btn_debounce.sv
// Per-button 2-FF synchroniser, debouncer and press detector.
// With UPDOWN_AUTO_REPEAT_EN defined it also raises periodic repeat events while held.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic other_stable,
  output logic stable,
  output logic press,
  output logic rpt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [DW-1:0] db_cnt;
  logic          stable_d;

  // A sample equal to the stable level restarts the run of differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_ff  <= '0;
      db_cnt   <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[0], btn};
      stable_d <= stable;
      if (sync_ff[1] == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync_ff[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign press = stable & ~stable_d;

`ifdef UPDOWN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_cnt;
  logic          r_rep;

  // r_cnt is 0 in the press cycle; first event at REPEAT_DELAY, then every REPEAT_PERIOD.
  assign rpt = stable && !other_stable &&
               (r_cnt == (r_rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end else if (!stable || other_stable) begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end else if (rpt) begin
      r_cnt <= RW'(1);
      r_rep <= 1'b1;
    end else begin
      r_cnt <= r_cnt + RW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = other_stable ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rpt = 1'b0;
`endif
endmodule

// File: rtl/updown_cmd_gen.sv
// Turns debounced up/down button presses into ARM/STEP commands for a 4-bit counter.
// UPDOWN_AUTO_REPEAT_EN enables hold-to-repeat in the button front ends.
module updown_cmd_gen
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic [3:0] q,
  output logic       t,
  output logic       M,
  output logic       limit
);
  logic stable_up, stable_dn, press_up, press_dn, rpt_up, rpt_dn;
  logic up_ev, dn_ev;
  state_t state, state_n;
  logic m_n, limit_n;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clock(clock), .reset(reset), .btn(btn_up), .other_stable(stable_dn),
    .stable(stable_up), .press(press_up), .rpt(rpt_up)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .clock(clock), .reset(reset), .btn(btn_dn), .other_stable(stable_up),
    .stable(stable_dn), .press(press_dn), .rpt(rpt_dn)
  );

  assign up_ev = press_up | rpt_up;
  assign dn_ev = press_dn | rpt_dn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      M     <= DIR_UP;
      limit <= 1'b0;
    end else begin
      state <= state_n;
      M     <= m_n;
      limit <= limit_n;
    end
  end

  // Direction is committed on entry to ARM so it is stable a full cycle before t.
  always_comb begin
    state_n = state;
    m_n     = M;
    limit_n = 1'b0;
    case (state)
      IDLE: begin
        if (up_ev && !dn_ev) begin
          if (q != CNT_MAX) begin
            state_n = ARM;
            m_n     = DIR_UP;
          end else begin
            limit_n = 1'b1;
          end
        end else if (dn_ev && !up_ev) begin
          if (q != CNT_MIN) begin
            state_n = ARM;
            m_n     = DIR_DN;
          end else begin
            limit_n = 1'b1;
          end
        end
      end
      ARM:     state_n = STEP;
      STEP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign t = (state == STEP);
endmodule

// File: tb/tb_updown_cmd_gen.sv
// Bench for updown_cmd_gen: vector table plus hand sequences, t/limit scoreboard and counter model.
module tb_updown_cmd_gen;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [3:0] q = 4'd0;
  logic       t, M, limit;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  int         cyc = 0;

  always #5 clock = ~clock;

  // Counter model attached downstream of the DUT.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (load)   q <= load_val;
    else if (t) q <= M ? q - 4'd1 : q + 4'd1;
  end

  updown_cmd_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
    .clock(clock), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .q(q), .t(t), .M(M), .limit(limit)
  );

  typedef struct { int cyc; logic m; } ev_t;
  typedef struct {
    logic [3:0] q0; logic up; logic dn; int hold;
    logic [3:0] qf; int steps; int lims;
  } vec_t;

  ev_t  tq[$];
  ev_t  lq[$];
  vec_t vecs[9];
  int   n_pass = 0, n_total = 0, t_seen = 0, l_seen = 0;
  logic prev_m = 1'b0, exp_m = 1'b0;
  logic [3:0] mq = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance to the next falling edge and score any t / limit pulse seen there.
  task automatic tick();
    ev_t e;
    @(negedge clock);
    if (t) begin
      t_seen++;
      if (tq.size() == 0) chk("t_unexpected_cycle", cyc, -1);
      else begin
        e = tq.pop_front();
        chk("t_cycle", cyc, e.cyc);
        chk("t_dir", int'(M), int'(e.m));
        chk("m_setup", int'(prev_m), int'(e.m));
      end
    end
    if (limit) begin
      l_seen++;
      if (lq.size() == 0) chk("limit_unexpected_cycle", cyc, -1);
      else begin
        e = lq.pop_front();
        chk("limit_cycle", cyc, e.cyc);
        chk("limit_m_kept", int'(M), int'(e.m));
      end
    end
    prev_m = M;
  endtask

  // e1 is the first edge sampling the raw button high; hold is edges it stays high.
  task automatic push_events(input int e1, input logic up, input logic dn, input int hold);
    int c, last;
`ifdef UPDOWN_AUTO_REPEAT_EN
    logic first;
    first = 1'b1;
`endif
    if (hold < D + 1 || (up && dn) || !(up || dn)) return;
    c    = e1 + D + 1;
    last = e1 + hold + D;
    while (c <= last) begin
      if (up ? (mq == 4'hF) : (mq == 4'h0)) lq.push_back('{c + 1, exp_m});
      else begin
        exp_m = dn;
        tq.push_back('{c + 2, dn});
        mq = up ? mq + 4'd1 : mq - 4'd1;
      end
`ifdef UPDOWN_AUTO_REPEAT_EN
      c += first ? 8 : 4;
      first = 1'b0;
`else
      c = last + 1;
`endif
    end
  endtask

  task automatic load_q(input logic [3:0] v);
    tick();
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
    mq = v;
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    tick();
    btn_up = up; btn_dn = dn;
    push_events(cyc + 1, up, dn, hold);
    repeat (hold) tick();
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (D + 12) tick();
  endtask

  task automatic end_checks(input string tag, input logic [3:0] qf, input int steps, input int lims,
                            input int s0, input int l0);
    chk({tag, "_t_pending"}, tq.size(), 0);
    chk({tag, "_limit_pending"}, lq.size(), 0);
    chk({tag, "_q"}, int'(q), int'(qf));
    chk({tag, "_steps"}, t_seen - s0, steps);
    chk({tag, "_limits"}, l_seen - l0, lims);
    tq.delete(); lq.delete();
  endtask

  initial begin
    int s0, l0, k;
    vecs[0] = '{4'd3,  1'b1, 1'b0, 6, 4'd4,  1, 0};
    vecs[1] = '{4'd5,  1'b0, 1'b1, 2, 4'd5,  0, 0};
    vecs[2] = '{4'd5,  1'b0, 1'b1, 8, 4'd4,  1, 0};
    vecs[3] = '{4'hF,  1'b1, 1'b0, 6, 4'hF,  0, 1};
    vecs[4] = '{4'd0,  1'b1, 1'b0, 6, 4'd1,  1, 0};
    vecs[5] = '{4'd0,  1'b0, 1'b1, 6, 4'd0,  0, 1};
    vecs[6] = '{4'd7,  1'b1, 1'b1, 6, 4'd7,  0, 0};
    vecs[7] = '{4'd7,  1'b0, 1'b1, 6, 4'd6,  1, 0};
    vecs[8] = '{4'hF,  1'b0, 1'b1, 6, 4'hE,  1, 0};

    repeat (3) tick();
    chk("rst_t", int'(t), 0);
    chk("rst_M", int'(M), 0);
    chk("rst_limit", int'(limit), 0);
    #2 reset = 1'b1;

    foreach (vecs[i]) begin
      load_q(vecs[i].q0);
      s0 = t_seen; l0 = l_seen;
      press(vecs[i].up, vecs[i].dn, vecs[i].hold);
      end_checks($sformatf("vec%0d", i), vecs[i].qf, vecs[i].steps, vecs[i].lims, s0, l0);
    end

    load_q(4'd3);
    s0 = t_seen; l0 = l_seen;
    press(1'b1, 1'b0, 20);
`ifdef UPDOWN_AUTO_REPEAT_EN
    end_checks("hold20", 4'd7, 4, 0, s0, l0);
`else
    end_checks("hold20", 4'd4, 1, 0, s0, l0);
`endif

    // Reset asserted while t is high: pulse must drop and no step follows.
    load_q(4'd9);
    s0 = t_seen;
    tick();
    btn_dn = 1'b1;
    push_events(cyc + 1, 1'b0, 1'b1, 8);
    k = 0;
    while (t_seen == s0 && k < 40) begin tick(); k++; end
    chk("mid_step_t_seen", t_seen - s0, 1);
    #2 reset = 1'b0; btn_dn = 1'b0;
    #1;
    chk("mid_rst_t", int'(t), 0);
    chk("mid_rst_M", int'(M), 0);
    chk("mid_rst_limit", int'(limit), 0);
    exp_m = 1'b0; mq = 4'd9;
    repeat (2) tick();
    #2 reset = 1'b1;
    s0 = t_seen; l0 = l_seen;
    repeat (20) tick();
    end_checks("post_rst", 4'd9, 0, 0, s0, l0);

    s0 = t_seen; l0 = l_seen;
    press(1'b0, 1'b1, 6);
    end_checks("after_rst", 4'd8, 1, 0, s0, l0);

`ifdef UPDOWN_AUTO_REPEAT_EN
    load_q(4'd10);
    s0 = t_seen; l0 = l_seen;
    press(1'b1, 1'b0, 40);
    end_checks("repeat40", 4'hF, 5, 4, s0, l0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
